apmu_ibex_pmu_counter_mo: RTL and testbench

//  Parametrised, multi-outstanding successor of the core-side PMU counter port. Sits between the ID/EX

---
 rtl/apmu_ibex_pkg.sv | 22 ++
 rtl/apmu_ibex_pmu_resp_fifo.sv | 60 ++++++
 rtl/apmu_ibex_pmu_counter_mo.sv | 158 +++++++++++++++
 tb/tb_apmu_ibex_pmu_counter_mo.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apmu_ibex_pkg.sv
// Shared types for the Ibex PMU counter port: op encoding seen by core and counter interface,
// plus the multi-outstanding controller state encoding.
package apmu_ibex_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;

    typedef enum logic [1:0] {
        PMC_MO_IDLE = 2'd0,
        PMC_MO_REQ  = 2'd1,
        PMC_MO_WFX  = 2'd2
    } pmc_mo_fsm_e;

    function automatic logic is_wfx_op(input pmc_op_e op);
        return (op == PMC_WFP) || (op == PMC_WFO);
    endfunction

endpackage

// File: rtl/apmu_ibex_pmu_resp_fifo.sv
// In-order response-tracking FIFO. A push is honoured when full only if a pop happens in the
// same cycle, so a full FIFO can keep streaming at unchanged occupancy.
module apmu_ibex_pmu_resp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CntW-1:0]  o_count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/apmu_ibex_pmu_counter_mo.sv
// Multi-outstanding PMU counter port between ID/EX and the counter interface.
//   state       | meaning
//   PMC_MO_IDLE | nothing outstanding
//   PMC_MO_REQ  | 1..MaxOutstanding PMC_REQ in flight, tracked in the we-FIFO
//   PMC_MO_WFX  | one WFP/WFO in flight, op replayed from r_wfx_op, timer running
module apmu_ibex_pmu_counter_mo
    import apmu_ibex_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutWidth   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output pmc_op_e                 counter_op_o,
    input  logic                    counter_gnt_i,
    input  logic                    counter_rvalid_i,
    input  logic                    counter_err_i,
    output logic [AddrWidth-1:0]    counter_addr_o,
    output logic                    counter_we_o,
    output logic [DataWidth-1:0]    counter_wdata_o,
    input  logic [DataWidth-1:0]    counter_rdata_i,
    input  logic                    pmc_req_i,
    input  pmc_op_e                 pmc_op_i,
    input  logic                    pmc_we_i,
    input  logic [DataWidth-1:0]    pmc_wdata_i,
    input  logic [AddrWidth-1:0]    adder_result_ex_i,
    input  logic [TimeoutWidth-1:0] wfx_timeout_i,
    output logic                    pmc_accept_o,
    output logic [DataWidth-1:0]    pmc_rdata_o,
    output logic                    pmc_rdata_valid_o,
    output logic                    pmc_resp_valid_o,
    output logic                    pmc_err_o,
    output logic                    pmc_spurious_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    pmc_mo_fsm_e             r_state;
    pmc_mo_fsm_e             w_state_next;
    pmc_op_e                 r_wfx_op;
    logic [TimeoutWidth-1:0] r_timer;
    logic                    r_spurious;

    logic                    w_fifo_push;
    logic                    w_fifo_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_we_head;
    logic [CntW-1:0]         w_fifo_count;
    logic                    w_req_ok;
    logic                    w_wfx_ok;
    logic                    w_wfx_issue;
    logic                    w_timeout;

    assign counter_addr_o  = adder_result_ex_i;
    assign counter_we_o    = pmc_we_i;
    assign counter_wdata_o = pmc_wdata_i;
    assign pmc_rdata_o     = counter_rdata_i;
    assign pmc_spurious_o  = r_spurious;

    apmu_ibex_pmu_resp_fifo #(
        .Depth (MaxOutstanding),
        .Width (1)
    ) u_resp_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (pmc_we_i),
        .o_data  (w_we_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // A response frees a slot in the same cycle, so a full FIFO can still take a new request.
    assign w_fifo_pop = (r_state == PMC_MO_REQ) & counter_rvalid_i & ~w_fifo_empty;
    assign w_req_ok   = pmc_req_i & (pmc_op_i == PMC_REQ) & (r_state != PMC_MO_WFX)
                      & (~w_fifo_full | w_fifo_pop);
    assign w_wfx_ok   = pmc_req_i & is_wfx_op(pmc_op_i) & (r_state == PMC_MO_IDLE) & w_fifo_empty;
    assign w_timeout  = (wfx_timeout_i != '0) & (r_timer == wfx_timeout_i - TimeoutWidth'(1));

    always_comb begin
        w_state_next      = r_state;
        counter_op_o      = PMC_IDLE;
        pmc_accept_o      = 1'b0;
        pmc_resp_valid_o  = 1'b0;
        pmc_rdata_valid_o = 1'b0;
        pmc_err_o         = 1'b0;
        w_fifo_push       = 1'b0;
        w_wfx_issue       = 1'b0;

        if (w_req_ok) begin
            counter_op_o = PMC_REQ;
            if (counter_gnt_i) begin
                pmc_accept_o = 1'b1;
                w_fifo_push  = 1'b1;
            end
        end else if (w_wfx_ok) begin
            counter_op_o = pmc_op_i;
            if (counter_gnt_i) begin
                pmc_accept_o = 1'b1;
                w_wfx_issue  = 1'b1;
            end
        end

        case (r_state)
            PMC_MO_IDLE: begin
                if (w_fifo_push)      w_state_next = PMC_MO_REQ;
                else if (w_wfx_issue) w_state_next = PMC_MO_WFX;
            end
            PMC_MO_REQ: begin
                if (w_fifo_pop) begin
                    pmc_resp_valid_o  = 1'b1;
                    pmc_err_o         = counter_err_i;
                    pmc_rdata_valid_o = ~w_we_head & ~counter_err_i;
                    if (!w_fifo_push && w_fifo_count == CntW'(1)) w_state_next = PMC_MO_IDLE;
                end
            end
            PMC_MO_WFX: begin
                if (counter_rvalid_i) begin
                    pmc_resp_valid_o  = 1'b1;
                    pmc_err_o         = counter_err_i;
                    pmc_rdata_valid_o = ~counter_err_i;
                    w_state_next      = PMC_MO_IDLE;
                end else if (w_timeout) begin
                    pmc_resp_valid_o  = 1'b1;
                    pmc_err_o         = 1'b1;
                    w_state_next      = PMC_MO_IDLE;
                end else begin
                    counter_op_o      = r_wfx_op;
                end
            end
            default: w_state_next = PMC_MO_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= PMC_MO_IDLE;
            r_wfx_op   <= PMC_IDLE;
            r_timer    <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wfx_issue) begin
                r_wfx_op <= pmc_op_i;
                r_timer  <= '0;
            end else if (r_state == PMC_MO_WFX && r_timer != '1) begin
                r_timer  <= r_timer + TimeoutWidth'(1);
            end
            if (counter_rvalid_i && r_state == PMC_MO_IDLE) r_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apmu_ibex_pmu_counter_mo.sv
// Directed bench for the multi-outstanding PMU counter port; expected values are hand-derived.
module tb_apmu_ibex_pmu_counter_mo;
    import apmu_ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    pmc_op_e     counter_op_o;
    logic        counter_gnt_i;
    logic        counter_rvalid_i;
    logic        counter_err_i;
    logic [31:0] counter_addr_o;
    logic        counter_we_o;
    logic [31:0] counter_wdata_o;
    logic [31:0] counter_rdata_i;
    logic        pmc_req_i;
    pmc_op_e     pmc_op_i;
    logic        pmc_we_i;
    logic [31:0] pmc_wdata_i;
    logic [31:0] adder_result_ex_i;
    logic [15:0] wfx_timeout_i;
    logic        pmc_accept_o;
    logic [31:0] pmc_rdata_o;
    logic        pmc_rdata_valid_o;
    logic        pmc_resp_valid_o;
    logic        pmc_err_o;
    logic        pmc_spurious_o;

    int n_checks = 0;
    int n_errors = 0;

    apmu_ibex_pmu_counter_mo dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .counter_op_o      (counter_op_o),
        .counter_gnt_i     (counter_gnt_i),
        .counter_rvalid_i  (counter_rvalid_i),
        .counter_err_i     (counter_err_i),
        .counter_addr_o    (counter_addr_o),
        .counter_we_o      (counter_we_o),
        .counter_wdata_o   (counter_wdata_o),
        .counter_rdata_i   (counter_rdata_i),
        .pmc_req_i         (pmc_req_i),
        .pmc_op_i          (pmc_op_i),
        .pmc_we_i          (pmc_we_i),
        .pmc_wdata_i       (pmc_wdata_i),
        .adder_result_ex_i (adder_result_ex_i),
        .wfx_timeout_i     (wfx_timeout_i),
        .pmc_accept_o      (pmc_accept_o),
        .pmc_rdata_o       (pmc_rdata_o),
        .pmc_rdata_valid_o (pmc_rdata_valid_o),
        .pmc_resp_valid_o  (pmc_resp_valid_o),
        .pmc_err_o         (pmc_err_o),
        .pmc_spurious_o    (pmc_spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkop(input string tag, input pmc_op_e obs, input pmc_op_e exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        pmc_req_i         = 1'b0;
        pmc_op_i          = PMC_IDLE;
        pmc_we_i          = 1'b0;
        pmc_wdata_i       = '0;
        adder_result_ex_i = '0;
        counter_rvalid_i  = 1'b0;
        counter_err_i     = 1'b0;
        counter_rdata_i   = '0;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        pmc_req_i         = 1'b1;
        pmc_op_i          = PMC_REQ;
        pmc_we_i          = we;
        adder_result_ex_i = addr;
        pmc_wdata_i       = wdata;
    endtask

    task automatic resp(input logic [31:0] data, input logic err);
        counter_rvalid_i = 1'b1;
        counter_rdata_i  = data;
        counter_err_i    = err;
    endtask

    initial begin
        rst_ni        = 1'b0;
        counter_gnt_i = 1'b1;
        wfx_timeout_i = '0;
        quiet();
        nxt();
        nxt();
        #1;
        chkop("rst_op", counter_op_o, PMC_IDLE);
        chk1("rst_accept", pmc_accept_o, 1'b0);
        chk1("rst_resp", pmc_resp_valid_o, 1'b0);
        chk1("rst_spurious", pmc_spurious_o, 1'b0);
        rst_ni = 1'b1;
        nxt();

        // Two back-to-back reads, responses on the following two cycles
        req(1'b0, 32'h10, '0); #1;
        chk1("t1_acc0", pmc_accept_o, 1'b1);
        chkop("t1_op0", counter_op_o, PMC_REQ);
        chkd("t1_addr0", counter_addr_o, 32'h10);
        nxt();
        req(1'b0, 32'h14, '0); #1;
        chk1("t1_acc1", pmc_accept_o, 1'b1);
        chkd("t1_addr1", counter_addr_o, 32'h14);
        nxt();
        quiet(); resp(32'hA, 1'b0); #1;
        chk1("t1_rv0", pmc_resp_valid_o, 1'b1);
        chk1("t1_rdv0", pmc_rdata_valid_o, 1'b1);
        chkd("t1_rd0", pmc_rdata_o, 32'hA);
        chk1("t1_err0", pmc_err_o, 1'b0);
        nxt();
        resp(32'hB, 1'b0); #1;
        chk1("t1_rv1", pmc_resp_valid_o, 1'b1);
        chk1("t1_rdv1", pmc_rdata_valid_o, 1'b1);
        chkd("t1_rd1", pmc_rdata_o, 32'hB);
        nxt();
        quiet(); #1;
        chk1("t1_idle_rv", pmc_resp_valid_o, 1'b0);
        nxt();

        // Third request held while full, accepted in the cycle a response frees a slot
        req(1'b0, 32'h20, '0); #1;
        chk1("t2_acc0", pmc_accept_o, 1'b1);
        nxt();
        req(1'b0, 32'h24, '0); #1;
        chk1("t2_acc1", pmc_accept_o, 1'b1);
        nxt();
        req(1'b0, 32'h28, '0); #1;
        chk1("t2_held_acc", pmc_accept_o, 1'b0);
        chkop("t2_held_op", counter_op_o, PMC_IDLE);
        nxt();
        resp(32'h1, 1'b0); #1;
        chk1("t2_pp_acc", pmc_accept_o, 1'b1);
        chkop("t2_pp_op", counter_op_o, PMC_REQ);
        chk1("t2_pp_rv", pmc_resp_valid_o, 1'b1);
        nxt();
        quiet(); resp(32'h2, 1'b0); #1;
        chk1("t2_drain0", pmc_resp_valid_o, 1'b1);
        nxt();
        resp(32'h3, 1'b0); #1;
        chk1("t2_drain1", pmc_resp_valid_o, 1'b1);
        chkd("t2_drain1_d", pmc_rdata_o, 32'h3);
        nxt();
        quiet(); #1;
        chk1("t2_idle_rv", pmc_resp_valid_o, 1'b0);

        // Write then read; then a read completing with error
        req(1'b1, 32'h30, 32'h55); #1;
        chk1("t3_wacc", pmc_accept_o, 1'b1);
        chk1("t3_we", counter_we_o, 1'b1);
        chkd("t3_wdata", counter_wdata_o, 32'h55);
        nxt();
        req(1'b0, 32'h30, '0); #1;
        chk1("t3_racc", pmc_accept_o, 1'b1);
        nxt();
        quiet(); resp(32'h0, 1'b0); #1;
        chk1("t3_wrv", pmc_resp_valid_o, 1'b1);
        chk1("t3_wrdv", pmc_rdata_valid_o, 1'b0);
        nxt();
        resp(32'h77, 1'b0); #1;
        chk1("t3_rrv", pmc_resp_valid_o, 1'b1);
        chk1("t3_rrdv", pmc_rdata_valid_o, 1'b1);
        chkd("t3_rdata", pmc_rdata_o, 32'h77);
        nxt();
        quiet(); req(1'b0, 32'h34, '0); #1;
        chk1("t3_eacc", pmc_accept_o, 1'b1);
        nxt();
        quiet(); resp(32'h9, 1'b1); #1;
        chk1("t3_erv", pmc_resp_valid_o, 1'b1);
        chk1("t3_eerr", pmc_err_o, 1'b1);
        chk1("t3_erdv", pmc_rdata_valid_o, 1'b0);
        nxt();
        quiet();

        // WFP timing out after 5 cycles; core op changes mid-wait
        wfx_timeout_i = 16'd5;
        pmc_req_i = 1'b1; pmc_op_i = PMC_WFP; #1;
        chk1("t4_acc", pmc_accept_o, 1'b1);
        chkop("t4_op_issue", counter_op_o, PMC_WFP);
        nxt();
        req(1'b0, 32'h40, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chkop($sformatf("t4_op_wait%0d", i), counter_op_o, PMC_WFP);
            chk1($sformatf("t4_acc_wait%0d", i), pmc_accept_o, 1'b0);
            chk1($sformatf("t4_rv_wait%0d", i), pmc_resp_valid_o, 1'b0);
            nxt();
        end
        quiet(); #1;
        chk1("t4_to_rv", pmc_resp_valid_o, 1'b1);
        chk1("t4_to_err", pmc_err_o, 1'b1);
        chk1("t4_to_rdv", pmc_rdata_valid_o, 1'b0);
        chkop("t4_to_op", counter_op_o, PMC_IDLE);
        nxt();
        #1;
        chk1("t4_idle_rv", pmc_resp_valid_o, 1'b0);
        chkop("t4_idle_op", counter_op_o, PMC_IDLE);

        // WFO where the response lands on the timeout cycle, then a spurious response
        wfx_timeout_i = 16'd3;
        pmc_req_i = 1'b1; pmc_op_i = PMC_WFO; #1;
        chk1("t5_acc", pmc_accept_o, 1'b1);
        nxt();
        quiet(); #1;
        chkop("t5_op_w0", counter_op_o, PMC_WFO);
        nxt();
        #1;
        chkop("t5_op_w1", counter_op_o, PMC_WFO);
        nxt();
        resp(32'hC, 1'b0); #1;
        chk1("t5_rv", pmc_resp_valid_o, 1'b1);
        chk1("t5_rdv", pmc_rdata_valid_o, 1'b1);
        chk1("t5_err", pmc_err_o, 1'b0);
        chkd("t5_rdata", pmc_rdata_o, 32'hC);
        nxt();
        resp(32'hD, 1'b0); #1;
        chk1("t5_idle_rv", pmc_resp_valid_o, 1'b0);
        chk1("t5_spur_pre", pmc_spurious_o, 1'b0);
        nxt();
        quiet(); #1;
        chk1("t5_spur_set", pmc_spurious_o, 1'b1);
        nxt();
        #1;
        chk1("t5_spur_sticky", pmc_spurious_o, 1'b1);

        // Timeout disabled: WFP waits until an error response arrives
        wfx_timeout_i = 16'd0;
        pmc_req_i = 1'b1; pmc_op_i = PMC_WFP; #1;
        chk1("t5b_acc", pmc_accept_o, 1'b1);
        nxt();
        quiet();
        for (int i = 0; i < 6; i++) nxt();
        #1;
        chk1("t5b_no_to", pmc_resp_valid_o, 1'b0);
        chkop("t5b_op", counter_op_o, PMC_WFP);
        resp(32'h0, 1'b1); #1;
        chk1("t5b_rv", pmc_resp_valid_o, 1'b1);
        chk1("t5b_err", pmc_err_o, 1'b1);
        chk1("t5b_rdv", pmc_rdata_valid_o, 1'b0);
        nxt();
        quiet();

        // Reset with two reads outstanding
        req(1'b0, 32'h50, '0); #1;
        chk1("t6_acc0", pmc_accept_o, 1'b1);
        nxt();
        req(1'b0, 32'h54, '0); #1;
        chk1("t6_acc1", pmc_accept_o, 1'b1);
        nxt();
        quiet(); rst_ni = 1'b0;
        nxt();
        rst_ni = 1'b1; #1;
        chkop("t6_op", counter_op_o, PMC_IDLE);
        chk1("t6_acc", pmc_accept_o, 1'b0);
        chk1("t6_rv", pmc_resp_valid_o, 1'b0);
        chk1("t6_spur_clr", pmc_spurious_o, 1'b0);
        resp(32'h5, 1'b0); #1;
        chk1("t6_late_rv", pmc_resp_valid_o, 1'b0);
        nxt();
        quiet(); #1;
        chk1("t6_late_spur", pmc_spurious_o, 1'b1);
        req(1'b0, 32'h60, '0); #1;
        chk1("t6_new_acc", pmc_accept_o, 1'b1);
        nxt();
        // Last entry pops while a new one is pushed: must stay in REQ
        req(1'b0, 32'h64, '0); resp(32'h6, 1'b0); #1;
        chk1("t6_pp_acc", pmc_accept_o, 1'b1);
        chk1("t6_pp_rv", pmc_resp_valid_o, 1'b1);
        nxt();
        quiet(); resp(32'h7, 1'b0); #1;
        chk1("t6_stay_rv", pmc_resp_valid_o, 1'b1);
        chkd("t6_stay_d", pmc_rdata_o, 32'h7);
        nxt();
        quiet();
        nxt();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
